// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, default widths, receiver state encoding
// and the bit positions of the per-burst error flags.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } rx_state_e;

  localparam int ERR_RESP_BIT = 0;
  localparam int ERR_ID_BIT   = 1;
  localparam int ERR_LAST_BIT = 2;

  // SLVERR and DECERR both carry RRESP[1]; OKAY and EXOKAY are clean.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full/empty
// fall out of an MSB compare. Head data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write; contents are meaningless until covered by the pointers.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_r_receiver.sv
// AXI R-channel receiver: one burst at a time, checks ID/RESP/LAST per beat and
// buffers beats for the compressor. Optional counters under AXI_R_RECEIVER_PERF_EN.
module axi_r_receiver
  import axi_pkg::*;
#(
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W,
  parameter int LEN_W  = AXI_LEN_W,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ID_W-1:0]   r_id,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  input  logic              r_valid,
  output logic              r_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done_valid,
  output logic [2:0]        done_err
`ifdef AXI_R_RECEIVER_PERF_EN
  ,
  output logic [31:0]       beat_count,
  output logic [15:0]       err_burst_count
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  rx_state_e         state_r;
  rx_state_e         state_s;
  logic [ID_W-1:0]   id_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  beat_cnt_r;
  logic [2:0]        err_r;
  logic [2:0]        err_s;
  logic              cmd_acc_s;
  logic              beat_acc_s;
  logic              last_beat_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W:0]   fifo_dout_s;

  assign cmd_ready   = (state_r == IDLE);
  assign r_ready     = (state_r == BURST) && !fifo_full_s;
  assign cmd_acc_s   = cmd_valid && cmd_ready;
  assign beat_acc_s  = r_valid && r_ready;
  assign last_beat_s = (beat_cnt_r == len_r);
  assign done_valid  = (state_r == DONE);
  assign done_err    = done_valid ? err_r : 3'b000;

  // Next-state decode; the burst ends on beat count alone, never on r_last.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_s = BURST;
        else           state_s = IDLE;
      end
      BURST: begin
        if (beat_acc_s && last_beat_s) state_s = DONE;
        else                           state_s = BURST;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sticky error accumulation for the beat being accepted this cycle.
  always_comb begin
    err_s = err_r;
    if (beat_acc_s) begin
      err_s[ERR_RESP_BIT] = err_r[ERR_RESP_BIT] | resp_is_err(r_resp);
      err_s[ERR_ID_BIT]   = err_r[ERR_ID_BIT]   | (r_id != id_r);
      err_s[ERR_LAST_BIT] = err_r[ERR_LAST_BIT] | (r_last != last_beat_s);
    end else begin
      err_s = err_r;
    end
  end

  // Burst context: state, latched command, beat counter and error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      id_r       <= {ID_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      beat_cnt_r <= {LEN_W{1'b0}};
      err_r      <= 3'b000;
    end else begin
      state_r <= state_s;
      if (cmd_acc_s) begin
        id_r       <= cmd_id;
        len_r      <= cmd_len;
        beat_cnt_r <= {LEN_W{1'b0}};
        err_r      <= 3'b000;
      end else if (beat_acc_s) begin
        err_r <= err_s;
        if (!last_beat_s) beat_cnt_r <= beat_cnt_r + LEN_ONE;
      end
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (beat_acc_s),
    .din  ({r_data, last_beat_s}),
    .pop  (out_valid && out_ready),
    .dout (fifo_dout_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_dout_s[DATA_W:1];
  assign out_last  = fifo_dout_s[0];

`ifdef AXI_R_RECEIVER_PERF_EN
  logic [31:0] beat_count_r;
  logic [15:0] err_burst_count_r;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count_r      <= 32'd0;
      err_burst_count_r <= 16'd0;
    end else begin
      if (beat_acc_s && (beat_count_r != 32'hFFFF_FFFF))
        beat_count_r <= beat_count_r + 32'd1;
      if (done_valid && (err_r != 3'b000) && (err_burst_count_r != 16'hFFFF))
        err_burst_count_r <= err_burst_count_r + 16'd1;
    end
  end

  assign beat_count      = beat_count_r;
  assign err_burst_count = err_burst_count_r;
`endif

endmodule

// File: tb/tb_axi_r_receiver.sv
// Bench for axi_r_receiver: directed and random bursts checked against a
// queue-based model of the beat stream and per-burst error status.
module tb_axi_r_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        done_valid;
  logic [2:0]  done_err;
`ifdef AXI_R_RECEIVER_PERF_EN
  logic [31:0] beat_count;
  logic [15:0] err_burst_count;
`endif

  always #5 clk = ~clk;

  axi_r_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done_valid(done_valid), .done_err(done_err)
`ifdef AXI_R_RECEIVER_PERF_EN
    , .beat_count(beat_count), .err_burst_count(err_burst_count)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int done_cyc = -100;
  int ordy_mode = 1;
  int perf_beats = 0;
  int perf_errs = 0;
  int n;

  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  logic [2:0]  done_q[$];

  logic [63:0] b_data[16];
  logic [3:0]  b_id[16];
  logic [1:0]  b_resp[16];
  logic        b_last[16];
  logic [3:0]  cur_id;
  int          cur_len;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records delivered beats and done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (done_valid) begin
        done_q.push_back(done_err);
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ordy();
    if (ordy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else                out_ready = (ordy_mode == 1);
  endtask

  // Clean burst table: correct id, OKAY/EXOKAY, r_last on the final beat.
  task automatic build(input logic [3:0] id, input int len);
    cur_id = id;
    cur_len = len;
    for (int i = 0; i < 16; i++) begin
      b_data[i] = {$urandom, $urandom};
      b_id[i]   = id;
      b_resp[i] = 2'($urandom_range(0, 1));
      b_last[i] = (i == len);
    end
  endtask

  function automatic logic [2:0] model_err();
    logic [2:0] e;
    e = 3'b000;
    for (int i = 0; i <= cur_len; i++) begin
      if (b_resp[i] == 2'b10 || b_resp[i] == 2'b11) e[0] = 1'b1;
      if (b_id[i] != cur_id) e[1] = 1'b1;
      if (b_last[i] != (i == cur_len)) e[2] = 1'b1;
    end
    return e;
  endfunction

  task automatic do_cmd();
    int t;
    t = 0;
    cmd_id = cur_id;
    cmd_len = 8'(cur_len);
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(posedge clk); #1; set_ordy();
      @(negedge clk);
      t++;
    end
    chk("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_id = 4'($urandom);
    cmd_len = 8'($urandom);
    set_ordy();
  endtask

  task automatic do_beats(input int from, input int to, input int budget, input bit gaps,
                          output int acc);
    int i;
    int t;
    i = from;
    t = 0;
    acc = 0;
    while (i <= to && t < budget) begin
      set_ordy();
      r_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      r_data  = b_data[i];
      r_id    = b_id[i];
      r_resp  = b_resp[i];
      r_last  = b_last[i];
      @(negedge clk);
      if (r_valid && r_ready) begin
        exp_q.push_back({(i == cur_len), b_data[i]});
        perf_beats++;
        last_acc_cyc = cyc;
        i++;
        acc++;
      end
      @(posedge clk); #1;
      t++;
    end
    r_valid = 1'b0;
  endtask

  task automatic finish_burst(input string tag);
    int t;
    logic [2:0] e;
    e = model_err();
    ordy_mode = 1;
    t = 0;
    while ((got_q.size() < exp_q.size() || t < 3) && t < 300) begin
      set_ordy();
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({tag, "_beat"}, got_q[k], exp_q[k]);
    chk({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, "_done_err"}, done_q[0], e);
    chk({tag, "_done_time"}, done_cyc, last_acc_cyc + 1);
    if (e != 3'b000) perf_errs++;
    exp_q.delete();
    got_q.delete();
    done_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = 4'd0; cmd_len = 8'd0;
    r_id = 4'd0; r_data = 64'd0; r_resp = 2'b00; r_last = 1'b0; r_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_r_ready", r_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", {out_last, out_data}, 65'd0);
    chk("rst_done", {done_valid, done_err}, 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic 4-beat clean burst, consumer always ready.
    ordy_mode = 1;
    build(4'd3, 3);
    for (int i = 0; i < 4; i++) b_resp[i] = 2'b00;
    do_cmd();
    do_beats(0, 3, 50, 1'b0, n);
    chk("basic_acc", n, 4);
    finish_burst("basic");

    // Backpressure: 10 beats, consumer stalled, FIFO holds 8.
    ordy_mode = 0;
    build(4'd3, 9);
    do_cmd();
    do_beats(0, 9, 30, 1'b1, n);
    chk("bp_acc_full", n, 8);
    @(negedge clk);
    chk("bp_r_ready_low", r_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    ordy_mode = 1;
    do_beats(8, 9, 100, 1'b1, n);
    chk("bp_acc_rest", n, 2);
    finish_burst("bp");

    // RESP and ID errors still forwarded.
    build(4'd3, 1);
    b_resp[0] = 2'b10;
    b_id[1] = 4'd5;
    do_cmd();
    do_beats(0, 1, 50, 1'b0, n);
    finish_burst("resp_id");

    // Early r_last: count still decides burst end.
    build(4'd3, 2);
    b_last[1] = 1'b1;
    do_cmd();
    do_beats(0, 2, 50, 1'b0, n);
    chk("early_last_acc", n, 3);
    finish_burst("early_last");

    // R traffic while idle is ignored.
    r_valid = 1'b1; r_data = 64'hDEAD_BEEF_0000_0001; r_id = 4'd3; r_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_r_ready", r_ready, 1'b0);
      @(posedge clk); #1;
    end
    r_valid = 1'b0;
    chk("idle_nbeats", got_q.size(), 0);
    chk("idle_ndone", done_q.size(), 0);

    // Reset mid-burst after 2 of 4 beats.
    ordy_mode = 0;
    build(4'd6, 3);
    do_cmd();
    do_beats(0, 1, 50, 1'b0, n);
    chk("mid_rst_acc", n, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); got_q.delete(); done_q.delete();
    perf_beats = 0; perf_errs = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    ordy_mode = 1;
    repeat (5) begin @(posedge clk); #1; set_ordy(); end
    chk("mid_rst_ndone", done_q.size(), 0);
    chk("mid_rst_nbeats", got_q.size(), 0);

    // Two 4-beat bursts, second with one SLVERR beat.
    build(4'd2, 3);
    do_cmd();
    do_beats(0, 3, 50, 1'b1, n);
    finish_burst("perf_a");
    build(4'd2, 3);
    b_resp[2] = 2'b10;
    do_cmd();
    do_beats(0, 3, 50, 1'b1, n);
    finish_burst("perf_b");
`ifdef AXI_R_RECEIVER_PERF_EN
    chk("perf_beats8", beat_count, perf_beats);
    chk("perf_errs1", err_burst_count, perf_errs);
`endif

    // Random bursts with random backpressure and sporadic errors.
    for (int b = 0; b < 8; b++) begin
      ordy_mode = 2;
      build(4'($urandom), $urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) b_resp[$urandom_range(0, cur_len)] = 2'($urandom_range(2, 3));
      if ($urandom_range(0, 3) == 0) b_id[$urandom_range(0, cur_len)] = cur_id + 4'd1;
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, cur_len);
        b_last[k] = ~b_last[k];
      end
      do_cmd();
      do_beats(0, cur_len, 400, 1'b1, n);
      chk("rand_acc", n, cur_len + 1);
      finish_burst("rand");
    end
`ifdef AXI_R_RECEIVER_PERF_EN
    chk("perf_beats", beat_count, perf_beats);
    chk("perf_errs", err_burst_count, perf_errs);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
